// File: rtl/pc_fetch_unit.sv
// Architectural PC plus the instruction-fetch phase (req/ack to imem, IR/IPC latch).
// Optional PC_ALIGN_CHECK_EN: misaligned redirects are dropped and raise a sticky align_err.
module pc_fetch_unit #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            fetch_en,
   input  logic            stall,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   output logic [PC_W-1:0] ipc,
   output logic [PC_W-1:0] pc,
   output logic            fetch_done,
   output logic            busy,
   output logic            align_err
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t          state_q;
   logic [PC_W-1:0] pc_q, ipc_q, addr_q, redir_addr_q;
   logic [31:0]     ir_q;
   logic            req_q, ack_q, done_q, pend_q, redir_pend_q, align_err_q;
   logic            pend_d, issue;
   logic [PC_W-1:0] tgt;
   logic            tgt_ok, br_ok, br_bad;

`ifdef PC_ALIGN_CHECK_EN
   assign tgt    = br_target;
   assign tgt_ok = (br_target[1:0] == 2'b00);
`else
   assign tgt    = {br_target[PC_W-1:2], 2'b00};
   assign tgt_ok = 1'b1;
`endif

   assign br_ok  = br_valid & tgt_ok;
   assign br_bad = br_valid & ~tgt_ok;

   // A fetch issues only from IDLE with nothing competing for the PC this cycle.
   assign issue = (state_q == IDLE) & (fetch_en | pend_q) & ~stall & ~br_valid & ~align_err_q;

   always_comb begin
      pend_d = pend_q;
      if (issue)         pend_d = 1'b0;
      else if (fetch_en) pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         ipc_q        <= '0;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC;
         ack_q        <= 1'b0;
         done_q       <= 1'b0;
         pend_q       <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_addr_q <= '0;
         align_err_q  <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         ack_q       <= 1'b0;
         done_q      <= ack_q;
         align_err_q <= align_err_q | br_bad;
         case (state_q)
            IDLE: begin
               if (br_ok) begin
                  pc_q <= tgt;
               end else if (issue) begin
                  req_q   <= 1'b1;
                  addr_q  <= pc_q;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  ir_q         <= imem_rdata;
                  ipc_q        <= addr_q;
                  req_q        <= 1'b0;
                  ack_q        <= 1'b1;
                  redir_pend_q <= 1'b0;
                  state_q      <= IDLE;
                  // A same-cycle redirect is the newest, so it beats any latched one.
                  if (br_ok)             pc_q <= tgt;
                  else if (redir_pend_q) pc_q <= redir_addr_q;
                  else                   pc_q <= addr_q + PC_W'(4);
               end else if (br_ok) begin
                  redir_pend_q <= 1'b1;
                  redir_addr_q <= tgt;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign ir         = ir_q;
   assign ipc        = ipc_q;
   assign pc         = pc_q;
   assign fetch_done = done_q;
   assign busy       = (state_q == WAIT);
   assign align_err  = align_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch latency, stall, redirects, wrap, async reset, alignment.
module tb_pc_fetch_unit;
   logic        clk, rstn, fetch_en, stall, br_valid, imem_ack;
   logic [31:0] br_target, imem_addr, imem_rdata, ir, ipc, pc;
   logic        imem_req, fetch_done, busy, align_err;
   int          checks = 0, failures = 0;

   pc_fetch_unit dut (
      .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .stall(stall),
      .br_valid(br_valid), .br_target(br_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ir(ir), .ipc(ipc), .pc(pc),
      .fetch_done(fetch_done), .busy(busy), .align_err(align_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      clk = 0; rstn = 0; fetch_en = 0; stall = 0; br_valid = 0;
      br_target = '0; imem_ack = 0; imem_rdata = '0;
      #12;
      chk("rst_pc", pc, 32'h3000);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ipc", ipc, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 0);
      chk("rst_addr", imem_addr, 32'h3000);
      chk("rst_done", {31'b0, fetch_done}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_align", {31'b0, align_err}, 0);
      @(posedge clk); #1; rstn = 1; tick();

      // basic fetch, ack in second request cycle
      fetch_en = 1; tick(); fetch_en = 0;
      chk("t1_req", {31'b0, imem_req}, 1);
      chk("t1_addr", imem_addr, 32'h3000);
      chk("t1_busy", {31'b0, busy}, 1);
      tick();
      chk("t1_req_hold", {31'b0, imem_req}, 1);
      imem_ack = 1; imem_rdata = 32'h2408_0005; tick(); imem_ack = 0;
      chk("t1_ir", ir, 32'h2408_0005);
      chk("t1_ipc", ipc, 32'h3000);
      chk("t1_pc", pc, 32'h3004);
      chk("t1_req_drop", {31'b0, imem_req}, 0);
      chk("t1_done_early", {31'b0, fetch_done}, 0);
      tick();
      chk("t1_done", {31'b0, fetch_done}, 1);
      tick();
      chk("t1_done_one", {31'b0, fetch_done}, 0);

      // fetch_en under stall is held pending
      do_reset();
      stall = 1; fetch_en = 1; tick(); fetch_en = 0;
      chk("t2_stall0", {31'b0, imem_req}, 0);
      tick();
      chk("t2_stall1", {31'b0, imem_req}, 0);
      tick();
      chk("t2_stall2", {31'b0, imem_req}, 0);
      stall = 0; tick();
      chk("t2_req", {31'b0, imem_req}, 1);
      chk("t2_addr", imem_addr, 32'h3000);
      imem_ack = 1; imem_rdata = 32'h0000_0001; tick(); imem_ack = 0;
      tick(); tick();
      chk("t2_pend_clr", {31'b0, imem_req}, 0);
      chk("t2_idle", {31'b0, busy}, 0);

      // redirect during WAIT applied at ack
      do_reset();
      fetch_en = 1; tick(); fetch_en = 0;
      br_valid = 1; br_target = 32'h3040; tick(); br_valid = 0;
      tick();
      imem_ack = 1; imem_rdata = 32'hAAAA_0001; tick(); imem_ack = 0;
      chk("t3_ir", ir, 32'hAAAA_0001);
      chk("t3_ipc", ipc, 32'h3000);
      chk("t3_pc", pc, 32'h3040);
      fetch_en = 1; tick(); fetch_en = 0;
      chk("t3_next_addr", imem_addr, 32'h3040);
      imem_ack = 1; imem_rdata = 32'h11; tick(); imem_ack = 0;
      chk("t3_pc_seq", pc, 32'h3044);

      // redirect coincident with ack
      fetch_en = 1; tick(); fetch_en = 0;
      chk("t4_addr", imem_addr, 32'h3044);
      imem_ack = 1; imem_rdata = 32'h22; br_valid = 1; br_target = 32'h3100;
      tick(); imem_ack = 0; br_valid = 0;
      chk("t4_pc", pc, 32'h3100);
      chk("t4_ipc", ipc, 32'h3044);
      chk("t4_ir", ir, 32'h22);

      // wrap at top of address space
      br_valid = 1; br_target = 32'hFFFF_FFFC; tick(); br_valid = 0;
      chk("t5_pc_redir", pc, 32'hFFFF_FFFC);
      fetch_en = 1; tick(); fetch_en = 0;
      chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
      imem_ack = 1; imem_rdata = 32'h33; tick(); imem_ack = 0;
      chk("t5_wrap", pc, 32'h0);
      chk("t5_ipc", ipc, 32'hFFFF_FFFC);

      // async reset mid-WAIT, late ack ignored
      fetch_en = 1; tick(); fetch_en = 0;
      chk("t5r_req", {31'b0, imem_req}, 1);
      #2 rstn = 0;
      #1;
      chk("t5r_req_drop", {31'b0, imem_req}, 0);
      chk("t5r_pc", pc, 32'h3000);
      @(posedge clk); #1; rstn = 1;
      imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 0;
      chk("t5r_ir", ir, 32'h0);
      chk("t5r_pc2", pc, 32'h3000);
      chk("t5r_busy", {31'b0, busy}, 0);
      tick();
      chk("t5r_done", {31'b0, fetch_done}, 0);

      // misaligned redirect
      br_valid = 1; br_target = 32'h3042; tick(); br_valid = 0;
`ifdef PC_ALIGN_CHECK_EN
      chk("t6_align", {31'b0, align_err}, 1);
      chk("t6_pc", pc, 32'h3000);
      fetch_en = 1; tick(); fetch_en = 0; tick();
      chk("t6_no_req", {31'b0, imem_req}, 0);
`else
      chk("t6_align", {31'b0, align_err}, 0);
      chk("t6_pc", pc, 32'h3040);
      fetch_en = 1; tick(); fetch_en = 0;
      chk("t6_addr", imem_addr, 32'h3040);
      imem_ack = 1; imem_rdata = 32'h44; tick(); imem_ack = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Holds the architectural PC and runs the instruction-fetch phase of the multicycle CPU.
- Issues a req/ack read to instruction memory and latches the returned instruction into IR.
- Exports the PC of the instruction in IR (ipc), which the branch-resolution stage uses as its base address.
- Accepts that stage's redirect (br_valid/br_target) and applies it to the next fetch address.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
PC_W, 32, PC/address width; instruction data is fixed at 32 bits

Ports:
clk  in  1  system clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
fetch_en  in  1  one-cycle request from control FSM to start a fetch
stall  in  1  holds off issuing a new fetch while high
br_valid  in  1  redirect strobe from branch-resolution stage
br_target  in  PC_W  redirect target address
imem_req  out  1  instruction memory read request
imem_addr  out  PC_W  instruction memory address
imem_ack  in  1  memory response valid; imem_rdata is valid in this cycle
imem_rdata  in  32  instruction word
ir  out  32  latched instruction
ipc  out  PC_W  PC of the instruction held in ir
pc  out  PC_W  current (next-to-fetch) PC
fetch_done  out  1  one-cycle pulse after ir/ipc are updated
busy  out  1  high while state is WAIT
align_err  out  1  sticky misaligned-redirect flag (feature-dependent)

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: pc=RESET_PC, ir=0, ipc=0, imem_req=0, imem_addr=RESET_PC, fetch_done=0, busy=0, align_err=0, fetch_pend=0, state=IDLE.
- Reset asserted mid-WAIT drops imem_req immediately. A late ack is ignored.
- FSM states: IDLE, WAIT. busy = (state==WAIT).
- fetch_pend: internal 1-deep flag. Set by fetch_en whenever a fetch cannot issue this cycle, i.e. any of: stall=1, br_valid=1, or state==WAIT.
  - fetch_en while fetch_pend is already set is absorbed (no counting).
  - fetch_pend is cleared when the pending fetch issues.
- IDLE:
  - br_valid=1: pc <= br_target. No issue this cycle.
  - Otherwise, if (fetch_en | fetch_pend) & !stall: imem_req <= 1, imem_addr <= pc, go to WAIT. First request cycle is the cycle after the trigger.
- WAIT:
  - imem_req and imem_addr stay stable until the ack cycle, inclusive.
  - On imem_ack: ir <= imem_rdata, ipc <= imem_addr, imem_req <= 0, go to IDLE, fetch_done pulses for one cycle on the next edge.
  - pc update on ack: pc <= imem_addr + 4 (mod 2^PC_W, wraps), unless a redirect is pending.
  - Redirect arriving in WAIT (br_valid): latched as redir_pend/redir_addr. The latest strobe overwrites earlier ones.
  - On ack with redirect pending: pc <= redir_addr (redir_addr wins over +4); redir_pend clears.
  - br_valid in the same cycle as ack counts as pending.
  - The in-flight fetch is never cancelled; ir/ipc always reflect the fetched address.
- Latency: fetch_en (stall=0, ack after N request cycles) -> fetch_done pulse N+1 cycles after the first req cycle.
- stall has no effect in WAIT.
- fetch_done, ir and ipc never change outside the ack-update edge.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - A redirect with target[1:0] != 0 sets align_err (sticky until reset).
  - That redirect is discarded; pc is unchanged.
  - No further fetches issue while align_err=1.
- Undefined: align_err is tied 0; targets are used with bits [1:0] forced to 00.

Test Plan:
- Reset, then fetch_en with ack 2 cycles after req and rdata=32'h2408_0005 -> imem_addr=32'h3000, ir=32'h2408_0005, ipc=32'h3000, pc=32'h3004, fetch_done is a single pulse.
- fetch_en with stall=1 held for 3 cycles -> no imem_req during stall; req at 32'h3000 one cycle after stall drops; fetch_pend cleared.
- br_valid=1 with br_target=32'h3040 in WAIT, ack arriving 2 cycles later -> ir/ipc from the original address, pc=32'h3040; next fetch addresses 32'h3040.
- br_valid and imem_ack in the same cycle, target 32'h3100 -> pc=32'h3100, not ipc+4.
- PC at 32'hFFFF_FFFC fetched -> pc wraps to 32'h0000_0000. rstn pulled low during WAIT -> imem_req=0 immediately, pc=32'h3000, later ack ignored.
- PC_ALIGN_CHECK_EN defined: br_target=32'h3042 -> align_err=1, pc unchanged, subsequent fetch_en issues no request. Macro undefined: pc=32'h3040.
